// File: rtl/a2d_pkg.sv
// Shared types and constants for the A/D round sequencer.
package a2d_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCnv,
      StWtCnv,
      StGap,
      StRd,
      StWtRd
   } state_e;

   // Physical ADC channel numbers in round order.
   localparam logic [2:0]  CH_BATT    = 3'd0;
   localparam logic [2:0]  CH_CURR    = 3'd1;
   localparam logic [2:0]  CH_BRAKE   = 3'd3;
   localparam logic [2:0]  CH_TORQUE  = 3'd4;

   // Slot index of the last channel in a round.
   localparam logic [1:0]  IDX_TORQUE = 2'd3;

   localparam logic [15:0] RD_CMD     = 16'h0000;

   // Map a round slot to its ADC channel number.
   function automatic logic [2:0] idx2ch(input logic [1:0] idx);
      logic [2:0] ch;
      case (idx)
         2'd0:    ch = CH_BATT;
         2'd1:    ch = CH_CURR;
         2'd2:    ch = CH_BRAKE;
         default: ch = CH_TORQUE;
      endcase
      return ch;
   endfunction

   function automatic logic [15:0] cnv_cmd(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

endpackage

// File: rtl/a2d_round_tmr.sv
// Free-running round timer; wrap is high in the cycle the count goes all-ones -> zero.
module a2d_round_tmr #(
   parameter int unsigned PERIOD_W = 14
) (
   input  logic clk,
   input  logic rst_n,
   output logic wrap
);

   localparam logic [PERIOD_W-1:0] ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

   logic [PERIOD_W-1:0] r_cnt;

   // Count every clock, rolling over naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + ONE;
      end
   end

   assign wrap = &r_cnt;

endmodule

// File: rtl/a2d_seq.sv
// A/D round sequencer: converts then reads batt, curr, brake, torque over SPI once per
// timer period. Define A2D_SEQ_AVG_EN to store a rounded running average instead of raw data.
module a2d_seq
   import a2d_pkg::*;
#(
   parameter int unsigned PERIOD_W = 14
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        snd,
   output logic [15:0] cmd,
   input  logic        done,
   input  logic [15:0] resp,
   output logic [11:0] batt,
   output logic [11:0] curr,
   output logic [11:0] brake,
   output logic [11:0] torque,
   output logic        cnv_cmplt
);

   state_e      r_state;
   state_e      w_next;
   logic [1:0]  r_idx;
   logic        r_cmplt;
   logic [11:0] r_res [4];
   logic        w_wrap;
   logic        w_snd;
   logic [15:0] w_cmd;
   logic        w_wr;
   logic [11:0] w_new;
   logic        unused_resp;

   assign unused_resp = ^resp[15:12];

   a2d_round_tmr #(
      .PERIOD_W(PERIOD_W)
   ) u_tmr (
      .clk  (clk),
      .rst_n(rst_n),
      .wrap (w_wrap)
   );

`ifdef A2D_SEQ_AVG_EN
   logic [12:0] w_sum;
   assign w_sum = {1'b0, r_res[r_idx]} + {1'b0, resp[11:0]} + 13'd1;
   assign w_new = w_sum[12:1];
`else
   assign w_new = resp[11:0];
`endif

   // Next-state and SPI request decode; round requests outside StIdle are simply not looked at.
   always_comb begin
      w_next = r_state;
      w_snd  = 1'b0;
      w_cmd  = RD_CMD;
      w_wr   = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_wrap) w_next = StCnv;
         end
         StCnv: begin
            w_snd  = 1'b1;
            w_cmd  = cnv_cmd(idx2ch(r_idx));
            w_next = StWtCnv;
         end
         StWtCnv: begin
            if (done) w_next = StGap;
         end
         StGap: begin
            w_next = StRd;
         end
         StRd: begin
            w_snd  = 1'b1;
            w_cmd  = RD_CMD;
            w_next = StWtRd;
         end
         StWtRd: begin
            if (done) begin
               w_wr   = 1'b1;
               w_next = (r_idx == IDX_TORQUE) ? StIdle : StCnv;
            end
         end
         default: w_next = StIdle;
      endcase
   end

   // State, channel slot and round-complete pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_idx   <= 2'd0;
         r_cmplt <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cmplt <= w_wr && (r_idx == IDX_TORQUE);
         if (w_wr) r_idx <= r_idx + 2'd1;
      end
   end

   // Result registers; only the current slot is written, on a read completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_res[i] <= 12'h000;
      end else if (w_wr) begin
         r_res[r_idx] <= w_new;
      end
   end

   assign snd       = w_snd;
   assign cmd       = w_cmd;
   assign batt      = r_res[0];
   assign curr      = r_res[1];
   assign brake     = r_res[2];
   assign torque    = r_res[3];
   assign cnv_cmplt = r_cmplt;

endmodule

// File: tb/tb_a2d_seq.sv
// Self-checking bench for a2d_seq with an SPI monarch model and a result scoreboard.
module tb_a2d_seq;

   localparam int unsigned PW  = 6;
   localparam int          PER = 64;
`ifdef A2D_SEQ_AVG_EN
   localparam logic [11:0] RD_BASE = 12'h0FF;
`else
   localparam logic [11:0] RD_BASE = 12'h100;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        snd;
   logic [15:0] cmd;
   logic        done = 1'b0;
   logic [15:0] resp = 16'h0000;
   logic [11:0] batt, curr, brake, torque;
   logic        cnv_cmplt;

   a2d_seq #(
      .PERIOD_W(PW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .snd      (snd),
      .cmd      (cmd),
      .done     (done),
      .resp     (resp),
      .batt     (batt),
      .curr     (curr),
      .brake    (brake),
      .torque   (torque),
      .cnv_cmplt(cnv_cmplt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   typedef struct {
      int          idx;
      logic [11:0] val;
   } res_t;

   res_t        exp_res[$];
   logic [15:0] exp_cmd[$];
   logic [11:0] mdl [4];
   res_t        pop_r;
   logic [15:0] pop_c;
   logic [11:0] rv;
   logic [2:0]  cur_ch;
   int          wait_cnt = 0;
   bit          is_rd = 0, phase_rd = 0, hold = 0, pend = 0, in_round = 0, gap_arm = 0;
   bit          first_rnd = 1, exp_c = 0;
   bit          stall_req = 0;
   int          stall_on_rd_ch = -1;
   int          inj_idle_req = 0, inj_idle_ack = 0, inj_gap_req = 0, inj_gap_ack = 0;
   int          tcnt = 0, last_start = 0, prev_start = 0, cmplt_cnt = 0, rd_cnt = 0;

   function automatic int ch_idx(input logic [2:0] ch);
      case (ch)
         3'd0:    return 0;
         3'd1:    return 1;
         3'd3:    return 2;
         3'd4:    return 3;
         default: return 0;
      endcase
   endfunction

   function automatic logic [11:0] next_val(input logic [11:0] old, input logic [11:0] nv);
`ifdef A2D_SEQ_AVG_EN
      logic [12:0] s;
      s = {1'b0, old} + {1'b0, nv} + 13'd1;
      return s[12:1];
`else
      return nv;
`endif
   endfunction

   task automatic chk_all(input string tag);
      check_val({tag, "_batt"}, {20'd0, batt}, {20'd0, mdl[0]});
      check_val({tag, "_curr"}, {20'd0, curr}, {20'd0, mdl[1]});
      check_val({tag, "_brake"}, {20'd0, brake}, {20'd0, mdl[2]});
      check_val({tag, "_torque"}, {20'd0, torque}, {20'd0, mdl[3]});
   endtask

   // Independent copy of the round timer.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tcnt <= 0;
      else        tcnt <= tcnt + 1;
   end

   // SPI monarch model and scoreboard, evaluated mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         done = 1'b0; resp = 16'h0000; wait_cnt = 0; hold = 0; pend = 0;
         in_round = 0; gap_arm = 0; first_rnd = 1; rd_cnt = 0; phase_rd = 0;
         exp_res.delete(); exp_cmd.delete();
         for (int i = 0; i < 4; i++) mdl[i] = 12'h000;
      end else begin
         done = 1'b0; resp = 16'h0000; exp_c = 0;
         if (pend) begin
            pop_r = exp_res.pop_front();
            case (pop_r.idx)
               0:       check_val("wr_batt", {20'd0, batt}, {20'd0, pop_r.val});
               1:       check_val("wr_curr", {20'd0, curr}, {20'd0, pop_r.val});
               2:       check_val("wr_brake", {20'd0, brake}, {20'd0, pop_r.val});
               default: check_val("wr_torque", {20'd0, torque}, {20'd0, pop_r.val});
            endcase
            mdl[pop_r.idx] = pop_r.val;
            pend = 0;
            exp_c = (pop_r.idx == 3);
         end
         if (cnv_cmplt || exp_c) check_val("cmplt_pulse", {31'd0, cnv_cmplt}, {31'd0, exp_c});
         if (cnv_cmplt) begin
            cmplt_cnt++;
            check_val("reads_per_round", rd_cnt, 4);
            rd_cnt = 0;
            in_round = 0;
            chk_all("rnd");
         end
         if (wait_cnt > 0 && !hold && !stall_req) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
               done = 1'b1;
               if (is_rd) begin
                  rv = RD_BASE + {9'd0, cur_ch};
                  resp = {4'hF, rv};
                  exp_res.push_back('{idx: ch_idx(cur_ch), val: next_val(mdl[ch_idx(cur_ch)], rv)});
                  pend = 1;
                  rd_cnt++;
               end else begin
                  resp = 16'hDEAD;
                  if (inj_gap_req != inj_gap_ack) begin
                     gap_arm = 1;
                     inj_gap_ack = inj_gap_req;
                  end
               end
            end
         end else if (gap_arm) begin
            done = 1'b1; resp = 16'h0EEE; gap_arm = 0;
         end else if (wait_cnt == 0 && !in_round && inj_idle_req != inj_idle_ack) begin
            done = 1'b1; resp = 16'h0ABC; inj_idle_ack = inj_idle_req;
         end
         if (snd) begin
            if (!in_round) begin
               in_round = 1; phase_rd = 0;
               prev_start = last_start; last_start = tcnt;
               if (first_rnd) check_val("first_start", tcnt, PER);
               else           check_val("start_align", tcnt % PER, 0);
               first_rnd = 0;
               exp_cmd.push_back(16'h0000); exp_cmd.push_back(16'h0000);
               exp_cmd.push_back(16'h0800); exp_cmd.push_back(16'h0000);
               exp_cmd.push_back(16'h1800); exp_cmd.push_back(16'h0000);
               exp_cmd.push_back(16'h2000); exp_cmd.push_back(16'h0000);
            end
            check_val("snd_busy", wait_cnt, 0);
            check_val("cmd_avail", {31'd0, exp_cmd.size() > 0}, 1);
            if (exp_cmd.size() > 0) begin
               pop_c = exp_cmd.pop_front();
               check_val("cmd", {16'd0, cmd}, {16'd0, pop_c});
            end
            is_rd = phase_rd;
            phase_rd = ~phase_rd;
            if (!is_rd) cur_ch = cmd[13:11];
            else if (stall_on_rd_ch == int'(cur_ch)) hold = 1;
            wait_cnt = 1;
         end else if (in_round) begin
            check_val("cmd_idle", {16'd0, cmd}, 0);
         end
      end
   end

   task automatic wait_cmplt(input string tag, input int n);
      int  c0;
      bit  ok;
      c0 = cmplt_cnt;
      ok = 0;
      for (int i = 0; i < n && !ok; i++) begin
         @(negedge clk); #1;
         if (cmplt_cnt != c0) ok = 1;
      end
      check_val({tag, "_timeout"}, {31'd0, ok}, 1);
   endtask

   task automatic chk_zero(input string tag);
      check_val({tag, "_snd"}, {31'd0, snd}, 0);
      check_val({tag, "_cmd"}, {16'd0, cmd}, 0);
      check_val({tag, "_cmplt"}, {31'd0, cnv_cmplt}, 0);
      check_val({tag, "_batt"}, {20'd0, batt}, 0);
      check_val({tag, "_curr"}, {20'd0, curr}, 0);
      check_val({tag, "_brake"}, {20'd0, brake}, 0);
      check_val({tag, "_torque"}, {20'd0, torque}, 0);
   endtask

   initial begin
      int  s0;
      int  c_before;
      bit  ok;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      @(negedge clk); #2 rst_n = 1'b1;

      // Two plain rounds.
      wait_cmplt("rnd1", 200);
`ifdef A2D_SEQ_AVG_EN
      check_val("avg1_batt", {20'd0, batt}, 32'h080);
`else
      check_val("r1_batt", {20'd0, batt}, 32'h100);
      check_val("r1_curr", {20'd0, curr}, 32'h101);
      check_val("r1_brake", {20'd0, brake}, 32'h103);
      check_val("r1_torque", {20'd0, torque}, 32'h104);
`endif
      wait_cmplt("rnd2", 200);
`ifdef A2D_SEQ_AVG_EN
      check_val("avg2_batt", {20'd0, batt}, 32'h0C0);
`else
      check_val("r2_batt", {20'd0, batt}, 32'h100);
`endif
      check_val("cmplt_count", cmplt_cnt, 2);

      // Stray done in IDLE.
      c_before = cmplt_cnt;
      inj_idle_req++;
      repeat (3) @(negedge clk);
      #1 chk_all("idle_done");
      check_val("idle_inj_taken", inj_idle_ack, inj_idle_req);
      check_val("idle_no_cmplt", cmplt_cnt, c_before);

      // Stray done in GAP.
      inj_gap_req++;
      wait_cmplt("gap_rnd", 200);
      check_val("gap_inj_taken", inj_gap_ack, inj_gap_req);

      // Stall a round past one timer period.
      stall_req = 1;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk); #1;
         if (in_round) ok = 1;
      end
      check_val("stall_start_timeout", {31'd0, ok}, 1);
      repeat (80) @(negedge clk);
      stall_req = 0;
      wait_cmplt("stall_rnd", 200);
      s0 = last_start;
      wait_cmplt("post_stall_rnd", 200);
      check_val("stall_gap", last_start - s0, 2 * PER);

      // Reset while waiting on the curr read.
      stall_on_rd_ch = 1;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk); #1;
         if (hold) ok = 1;
      end
      check_val("hold_timeout", {31'd0, ok}, 1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("mid_rst");
      stall_on_rd_ch = -1;
      repeat (3) @(negedge clk);
      #1 chk_zero("held_rst");
      #1 rst_n = 1'b1;
      wait_cmplt("rst_rnd", 200);
`ifdef A2D_SEQ_AVG_EN
      check_val("rst_avg_batt", {20'd0, batt}, 32'h080);
`else
      check_val("rst_batt", {20'd0, batt}, 32'h100);
      check_val("rst_curr", {20'd0, curr}, 32'h101);
`endif
      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
